fetch_prefetch_buffer: RTL

- Instruction-fetch front end feeding the CPU core's Instruction input.
- Issues sequential word fetches to instruction memory over a valid/ready request channel and accepts in-order responses.
- Queues fetched words with their PCs in a DEPTH-entry FIFO and hands them to the core through a valid/ready pair.
- On branch redirect, flushes the FIFO, discards stale in-flight responses, and restarts fetch at the new PC.

---
 rtl/fetch_prefetch_buffer.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/fetch_prefetch_buffer.sv
// Instruction-fetch front end: issues sequential word fetches under a credit
// limit, queues returned words with their PCs in a small FIFO and presents the
// head to the core. A redirect flushes the queue, restarts fetch at the new PC
// and silently drops responses still in flight for the old stream.
module fetch_prefetch_buffer #(
  parameter int           DEPTH    = 4,
  parameter int           N        = 32,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   redirect,
  input  logic [N-1:0]           redirect_pc,
  output logic                   imem_req_valid,
  input  logic                   imem_req_ready,
  output logic [N-1:0]           imem_addr,
  input  logic                   imem_resp_valid,
  input  logic [N-1:0]           imem_resp_data,
  output logic                   inst_valid,
  input  logic                   inst_ready,
  output logic [N-1:0]           inst_data,
  output logic [N-1:0]           inst_pc,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_EXT = (CW+1)'(DEPTH);

  typedef enum logic {FETCH, DISCARD} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  fetch_pc_q, fetch_pc_d;
  logic [N-1:0]  resp_pc_q, resp_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;

  logic [N-1:0]  fifo_data [DEPTH];
  logic [N-1:0]  fifo_pc   [DEPTH];

  logic          req_acc;
  logic [CW:0]   credit_sum;
  logic [CW-1:0] stale;
  logic          push;
  logic          pop;

  // PC arithmetic wraps modulo 2^N.
  function automatic logic [N-1:0] pc_inc(input logic [N-1:0] pc);
    return pc + N'(4);
  endfunction

  assign imem_addr  = fetch_pc_q;
  assign occupancy  = count_q;
  assign inst_valid = (count_q != '0);
  assign inst_data  = inst_valid ? fifo_data[rd_ptr_q] : '0;
  assign inst_pc    = inst_valid ? fifo_pc[rd_ptr_q]   : '0;
  assign pop        = inst_valid && inst_ready;
  // Responses only enter the queue in FETCH; in the redirect cycle they are stale.
  assign push       = (state_q == FETCH) && imem_resp_valid && !redirect;

  // Request issue, credit accounting and FETCH/DISCARD next-state logic.
  always_comb begin
    credit_sum     = {1'b0, count_q} + {1'b0, outstanding_q};
    imem_req_valid = !rst && !redirect && (state_q == FETCH) && (credit_sum < DEPTH_EXT);
    req_acc        = imem_req_valid && imem_req_ready;
    stale          = outstanding_q + CW'(req_acc) - CW'(imem_resp_valid);
    state_d        = state_q;
    fetch_pc_d     = fetch_pc_q;
    resp_pc_d      = resp_pc_q;
    outstanding_d  = stale;
    discard_d      = discard_q;
    if (redirect) begin
      fetch_pc_d = redirect_pc;
      resp_pc_d  = redirect_pc;
      discard_d  = stale;
      state_d    = (stale != '0) ? DISCARD : FETCH;
    end else begin
      case (state_q)
        FETCH: begin
          if (req_acc)         fetch_pc_d = pc_inc(fetch_pc_q);
          if (imem_resp_valid) resp_pc_d  = pc_inc(resp_pc_q);
        end
        DISCARD: begin
          if (imem_resp_valid) discard_d = discard_q - CW'(1);
          if ((discard_q == '0) || (imem_resp_valid && (discard_q == CW'(1))))
            state_d = FETCH;
        end
        default: state_d = FETCH;
      endcase
    end
  end

  // FIFO pointer and occupancy update; a redirect empties the queue.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (redirect) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= FETCH;
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  // FIFO storage: instruction word and its PC, written at the tail.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr_q] <= imem_resp_data;
      fifo_pc[wr_ptr_q]   <= resp_pc_q;
    end
  end

  // The credit limit must keep responses from landing in a full queue.
  always_ff @(posedge clk) begin
    if (!rst) assert (!(push && !pop && (count_q == CW'(DEPTH))));
  end

endmodule
